// File: rtl/instr_pkg.sv
// Shared types and constants for the light-grid puzzle text parsers.
// Holds the field widths, the op encoding, the instruction word layout
// and the ASCII control characters recognised by the parser.
package instr_pkg;

  localparam int POSITION_WIDTH    = 12;
  localparam int INSTRUCTION_WIDTH = 2 + 4 * POSITION_WIDTH;

  // 2'b00 is reserved to mean "no op recognised yet" and is never emitted.
  typedef enum logic [1:0] {
    OP_NONE   = 2'b00,
    OP_ON     = 2'b01,
    OP_OFF    = 2'b10,
    OP_TOGGLE = 2'b11
  } op_t;

  typedef logic [POSITION_WIDTH-1:0] position_t;

  typedef struct packed {
    op_t       op;
    position_t x0;
    position_t y0;
    position_t x1;
    position_t y1;
  } instr_t;

  localparam logic [7:0] CH_LF    = 8'h0A;
  localparam logic [7:0] CH_CR    = 8'h0D;
  localparam logic [7:0] CH_COMMA = 8'h2C;
  localparam logic [7:0] CH_NUL   = 8'h00;

endpackage

// File: rtl/decimal_accumulator.sv
// Decimal digit accumulator: detects ASCII digits and builds value = value*10 + digit.
// overflow flags (combinationally) that the presented digit would exceed WIDTH bits.
// clear has priority over shift; with neither asserted the value holds.
module decimal_accumulator #(
  parameter int WIDTH      = 12,
  parameter int CHAR_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [CHAR_WIDTH-1:0] char_in,
  input  logic                  shift,
  input  logic                  clear,
  output logic                  is_digit,
  output logic                  overflow,
  output logic [WIDTH-1:0]      value
);

  localparam int SUM_WIDTH = WIDTH + 4;

  logic [3:0]           digit;
  logic [SUM_WIDTH-1:0] sum;

  // Digit decode and the candidate next value, widened so overflow is visible.
  always_comb begin
    is_digit = (char_in >= CHAR_WIDTH'(48)) && (char_in <= CHAR_WIDTH'(57));
    digit    = 4'(char_in - CHAR_WIDTH'(48));
    sum      = SUM_WIDTH'(value) * SUM_WIDTH'(10) + SUM_WIDTH'(digit);
    overflow = is_digit && (sum[SUM_WIDTH-1:WIDTH] != '0);
  end

  // Accumulator register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      value <= '0;
    end else if (clear) begin
      value <= '0;
    end else if (shift && is_digit) begin
      value <= sum[WIDTH-1:0];
    end
  end

endmodule

// File: rtl/instr_text_parser.sv
// ASCII instruction-line parser: "turn on|turn off|toggle X0,Y0 through X1,Y1\n" -> {op,x0,y0,x1,y1}.
// instr_valid one cycle after the terminating '\n' (or 0x00); end_of_file after the final instruction.
// No backpressure; optional grid range check enabled by INSTR_TEXT_PARSER_RANGE_CHECK_EN.
module instr_text_parser #(
  parameter int INBOUND_DATA_WIDTH = 8,
  parameter int POSITION_WIDTH     = 12,
  parameter int GRID_SIZE          = 1000,
  parameter int INSTRUCTION_WIDTH  = 2 + 4 * POSITION_WIDTH
) (
  input  logic                          clk,
  input  logic                          reset_n,
  input  logic                          inbound_valid,
  input  logic [INBOUND_DATA_WIDTH-1:0] inbound_data,
  output logic                          instr_valid,
  output logic [INSTRUCTION_WIDTH-1:0]  instr_data,
  output logic                          end_of_file,
  output logic                          parse_error
);
  import instr_pkg::*;

  if (INSTRUCTION_WIDTH != 2 + 4 * POSITION_WIDTH) begin : g_bad_width
    $error("instr_text_parser: INSTRUCTION_WIDTH must equal 2+4*POSITION_WIDTH");
  end

  typedef enum logic [2:0] {
    S_LINE_START, S_OP_TEXT, S_NUMBERS, S_ERROR_SKIP, S_EOF
  } state_t;

  localparam logic [INBOUND_DATA_WIDTH-1:0] C_LF  = INBOUND_DATA_WIDTH'(CH_LF);
  localparam logic [INBOUND_DATA_WIDTH-1:0] C_CR  = INBOUND_DATA_WIDTH'(CH_CR);
  localparam logic [INBOUND_DATA_WIDTH-1:0] C_NUL = INBOUND_DATA_WIDTH'(CH_NUL);
  localparam logic [INBOUND_DATA_WIDTH-1:0] C_O   = INBOUND_DATA_WIDTH'(8'h6F);
  localparam logic [INBOUND_DATA_WIDTH-1:0] C_U   = INBOUND_DATA_WIDTH'(8'h75);
  localparam logic [INBOUND_DATA_WIDTH-1:0] C_N   = INBOUND_DATA_WIDTH'(8'h6E);
  localparam logic [INBOUND_DATA_WIDTH-1:0] C_F   = INBOUND_DATA_WIDTH'(8'h66);

  state_t                    state;
  logic [2:0]                col;
  logic                      is_turn;
  op_t                       op;
  logic [2:0]                idx;
  logic                      in_num;
  logic                      eof_pend;
  logic [POSITION_WIDTH-1:0] field [4];

  logic                      is_lf, is_cr, is_nul, is_digit, ovf;
  logic                      acc_shift, acc_clear, range_ok, line_ok;
  logic [POSITION_WIDTH-1:0] acc;
  logic [POSITION_WIDTH-1:0] eff [4];
  logic [2:0]                eff_idx;

  decimal_accumulator #(
    .WIDTH      (POSITION_WIDTH),
    .CHAR_WIDTH (INBOUND_DATA_WIDTH)
  ) u_acc (
    .clk      (clk),
    .reset_n  (reset_n),
    .char_in  (inbound_data),
    .shift    (acc_shift),
    .clear    (acc_clear),
    .is_digit (is_digit),
    .overflow (ovf),
    .value    (acc)
  );

  // Character classes and the line as it would look if it ended on this character.
  always_comb begin
    is_lf     = (inbound_data == C_LF);
    is_cr     = (inbound_data == C_CR);
    is_nul    = (inbound_data == C_NUL);
    acc_shift = inbound_valid && is_digit && (state == S_OP_TEXT || state == S_NUMBERS);
    acc_clear = inbound_valid && !is_digit && !is_cr;
    eff_idx   = idx + {2'b00, in_num};
    for (int i = 0; i < 4; i++) begin
      eff[i] = (in_num && idx == 3'(i)) ? acc : field[i];
    end
`ifdef INSTR_TEXT_PARSER_RANGE_CHECK_EN
    range_ok = (int'(eff[0]) < GRID_SIZE) && (int'(eff[1]) < GRID_SIZE) &&
               (int'(eff[2]) < GRID_SIZE) && (int'(eff[3]) < GRID_SIZE) &&
               (eff[0] <= eff[2]) && (eff[1] <= eff[3]);
`else
    range_ok = 1'b1;
`endif
    line_ok = (eff_idx == 3'd4) && (op != OP_NONE) && range_ok;
  end

  // Line-parsing FSM with registered strobes and sticky error.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= S_LINE_START;
      col         <= '0;
      is_turn     <= 1'b0;
      op          <= OP_NONE;
      idx         <= '0;
      in_num      <= 1'b0;
      eof_pend    <= 1'b0;
      for (int i = 0; i < 4; i++) field[i] <= '0;
      instr_valid <= 1'b0;
      instr_data  <= '0;
      end_of_file <= 1'b0;
      parse_error <= 1'b0;
    end else begin
      instr_valid <= 1'b0;
      end_of_file <= eof_pend;
      eof_pend    <= 1'b0;
      if (inbound_valid && !is_cr && state != S_EOF) begin
        if (is_nul) begin
          state <= S_EOF;
          if ((state == S_OP_TEXT || state == S_NUMBERS) && line_ok) begin
            instr_valid <= 1'b1;
            instr_data  <= {op, eff[0], eff[1], eff[2], eff[3]};
            eof_pend    <= 1'b1;
          end else begin
            end_of_file <= 1'b1;
            if (state == S_OP_TEXT || state == S_NUMBERS) parse_error <= 1'b1;
          end
        end else if (is_lf && state != S_LINE_START) begin
          if (state != S_ERROR_SKIP) begin
            if (line_ok) begin
              instr_valid <= 1'b1;
              instr_data  <= {op, eff[0], eff[1], eff[2], eff[3]};
            end else begin
              parse_error <= 1'b1;
            end
          end
          state   <= S_LINE_START;
          idx     <= '0;
          in_num  <= 1'b0;
          op      <= OP_NONE;
          is_turn <= 1'b0;
        end else begin
          case (state)
            S_LINE_START: begin
              if (!is_lf) begin
                state <= S_OP_TEXT;
                col   <= 3'd1;
              end
            end
            S_OP_TEXT: begin
              if (is_digit) begin
                state  <= S_NUMBERS;
                in_num <= 1'b1;
              end else begin
                if (col == 3'd1 && inbound_data == C_O) op <= OP_TOGGLE;
                if (col == 3'd1 && inbound_data == C_U) is_turn <= 1'b1;
                if (col == 3'd6 && is_turn && inbound_data == C_N) op <= OP_ON;
                if (col == 3'd6 && is_turn && inbound_data == C_F) op <= OP_OFF;
                if (col != 3'd7) col <= col + 3'd1;
              end
            end
            S_NUMBERS: begin
              if (is_digit) begin
                // A fifth number or a value wider than a field poisons the line.
                if ((!in_num && idx == 3'd4) || ovf) begin
                  state       <= S_ERROR_SKIP;
                  parse_error <= 1'b1;
                end else begin
                  in_num <= 1'b1;
                end
              end else if (in_num) begin
                field[idx[1:0]] <= acc;
                idx             <= idx + 3'd1;
                in_num          <= 1'b0;
              end
            end
            default: ;
          endcase
        end
      end
    end
  end

endmodule

// File: tb/tb_instr_text_parser.sv
// Directed bench for instr_text_parser: byte strings in, scoreboard of expected strobes.
// Expected instructions/EOF pulses are queued with their due cycle and matched against observed strobes.
// Sticky parse_error and reset values are checked directly at each step.
module tb_instr_text_parser;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        inbound_valid;
  logic [7:0]  inbound_data;
  logic        instr_valid;
  logic [49:0] instr_data;
  logic        end_of_file;
  logic        parse_error;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  typedef struct {
    bit          eof;
    logic [49:0] data;
    int          at;
  } ev_t;

  ev_t exp_q[$];
  ev_t obs_q[$];
  ev_t mon_ev;

  instr_text_parser dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .inbound_valid (inbound_valid),
    .inbound_data  (inbound_data),
    .instr_valid   (instr_valid),
    .instr_data    (instr_data),
    .end_of_file   (end_of_file),
    .parse_error   (parse_error)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Record every strobe with the cycle it was visible in.
  always @(negedge clk) begin
    if (instr_valid) begin
      mon_ev.eof = 1'b0; mon_ev.data = instr_data; mon_ev.at = cyc;
      obs_q.push_back(mon_ev);
    end
    if (end_of_file) begin
      mon_ev.eof = 1'b1; mon_ev.data = '0; mon_ev.at = cyc;
      obs_q.push_back(mon_ev);
    end
  end

  function automatic logic [49:0] mk(logic [1:0] op, int x0, int y0, int x1, int y1);
    return {op, 12'(x0), 12'(y0), 12'(x1), 12'(y1)};
  endfunction

  task automatic chk(string tag, logic [63:0] got, logic [63:0] want);
    total++;
    assert (got === want) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, want);
    end
  endtask

  task automatic push_exp(bit eof, logic [49:0] d, int at);
    ev_t e;
    e.eof = eof; e.data = d; e.at = at;
    exp_q.push_back(e);
  endtask

  task automatic send_byte(input logic [7:0] c, output int at);
    @(posedge clk); #1;
    inbound_valid = 1'b1;
    inbound_data  = c;
    @(posedge clk); #1;
    at = cyc;
    inbound_valid = 1'b0;
    repeat (6) @(posedge clk);
  endtask

  task automatic send_str(input string s, output int at);
    for (int i = 0; i < s.len(); i++) send_byte(s[i], at);
  endtask

  task automatic check_sb(string tag);
    ev_t e, o;
    repeat (3) @(posedge clk); #1;
    chk({tag, "_count"}, 64'(obs_q.size()), 64'(exp_q.size()));
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front();
      o = obs_q.pop_front();
      chk({tag, "_kind"}, 64'(o.eof), 64'(e.eof));
      chk({tag, "_data"}, 64'(o.data), 64'(e.data));
      chk({tag, "_cycle"}, 64'(o.at), 64'(e.at));
    end
    exp_q.delete();
    obs_q.delete();
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    reset_n = 1'b0;
    #1;
    chk("rst_valid", 64'(instr_valid), 64'(0));
    chk("rst_data",  64'(instr_data),  64'(0));
    chk("rst_eof",   64'(end_of_file), 64'(0));
    chk("rst_perr",  64'(parse_error), 64'(0));
    @(posedge clk); #1;
    reset_n = 1'b1;
    obs_q.delete();
  endtask

  initial begin
    int at;
    reset_n       = 1'b0;
    inbound_valid = 1'b0;
    inbound_data  = 8'h00;
    #2;
    chk("init_valid", 64'(instr_valid), 64'(0));
    chk("init_data",  64'(instr_data),  64'(0));
    chk("init_eof",   64'(end_of_file), 64'(0));
    chk("init_perr",  64'(parse_error), 64'(0));
    repeat (3) @(posedge clk); #1;
    reset_n = 1'b1;

    // Full-range turn on
    send_str("turn on 0,0 through 999,999\n", at);
    push_exp(1'b0, mk(2'b01, 0, 0, 999, 999), at);
    check_sb("on_full");
    chk("on_full_perr", 64'(parse_error), 64'(0));
    chk("on_full_hold", 64'(instr_data), 64'(mk(2'b01, 0, 0, 999, 999)));

    // Back-to-back toggle and turn off
    send_str("toggle 461,550 through 564,900\n", at);
    push_exp(1'b0, mk(2'b11, 461, 550, 564, 900), at);
    send_str("turn off 370,39 through 425,839\n", at);
    push_exp(1'b0, mk(2'b10, 370, 39, 425, 839), at);
    check_sb("two_lines");

    // Blank lines and carriage returns, including one inside a number
    send_str("\015\n\nturn off 7,8\015 through 9,1\0150\015\n", at);
    push_exp(1'b0, mk(2'b10, 7, 8, 9, 10), at);
    check_sb("cr_blank");
    chk("cr_blank_perr", 64'(parse_error), 64'(0));

    // Reversed ranges and the widest representable coordinate
    send_str("turn on 10,10 through 5,20\n", at);
`ifndef INSTR_TEXT_PARSER_RANGE_CHECK_EN
    push_exp(1'b0, mk(2'b01, 10, 10, 5, 20), at);
`endif
    send_str("toggle 4095,0 through 0,4095\n", at);
`ifndef INSTR_TEXT_PARSER_RANGE_CHECK_EN
    push_exp(1'b0, mk(2'b11, 4095, 0, 0, 4095), at);
`endif
    check_sb("range");
`ifdef INSTR_TEXT_PARSER_RANGE_CHECK_EN
    chk("range_perr", 64'(parse_error), 64'(1));
`else
    chk("range_perr", 64'(parse_error), 64'(0));
`endif

    // Overflow, fifth number and missing number are dropped; good line still passes
    send_str("turn on 5000,1 through 2,3\n", at);
    chk("ovf_perr", 64'(parse_error), 64'(1));
    send_str("turn on 1,2 through 3,4\n", at);
    push_exp(1'b0, mk(2'b01, 1, 2, 3, 4), at);
    send_str("toggle 4096,0 through 1,1\n", at);
    send_str("toggle 1,2 through 3,4,5\n", at);
    send_str("toggle 1,2 through 3\n", at);
    check_sb("errors");
    chk("errors_sticky", 64'(parse_error), 64'(1));

    // Reset mid-line discards the partial line
    send_str("turn on 12,3", at);
    do_reset();
    send_str("toggle 0,0 through 1,1\n", at);
    push_exp(1'b0, mk(2'b11, 0, 0, 1, 1), at);
    check_sb("after_reset");
    chk("after_reset_perr", 64'(parse_error), 64'(0));

    // EOF with a complete unterminated line: instr at N+1, eof at N+2, then silence
    send_str("toggle 1,2 through 3,4", at);
    send_byte(8'h00, at);
    push_exp(1'b0, mk(2'b11, 1, 2, 3, 4), at);
    push_exp(1'b1, '0, at + 1);
    send_str("turn on 1,1 through 2,2\n", at);
    send_byte(8'h00, at);
    check_sb("eof_pend");
    chk("eof_pend_perr", 64'(parse_error), 64'(0));

    // EOF with nothing pending
    do_reset();
    send_str("\n", at);
    send_byte(8'h00, at);
    push_exp(1'b1, '0, at);
    check_sb("eof_clean");
    chk("eof_clean_perr", 64'(parse_error), 64'(0));

    // EOF on an incomplete line
    do_reset();
    send_str("turn on 1,2", at);
    send_byte(8'h00, at);
    push_exp(1'b1, '0, at);
    check_sb("eof_partial");
    chk("eof_partial_perr", 64'(parse_error), 64'(1));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
